// File: rtl/aquila_device_req_queue.sv
// Request FIFO plus single-outstanding issue FSM in front of the uncached AXI-Lite device port.
// Define AQUILA_DEV_TIMEOUT_EN to add the WAIT watchdog, error responses and the DRAIN state.
module aquila_device_req_queue #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_rw_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    output logic                    rsp_rw_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_error_o,
    output logic                    dev_strobe_o,
    output logic [ADDR_WIDTH-1:0]   dev_addr_o,
    output logic                    dev_rw_o,
    output logic [DATA_WIDTH/8-1:0] dev_byte_enable_o,
    output logic [DATA_WIDTH-1:0]   dev_core2dev_data_o,
    input  logic                    dev_data_ready_i,
    input  logic [DATA_WIDTH-1:0]   dev_dev2core_data_i,
    output logic                    busy_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int PTR_W    = IDX_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("aquila_device_req_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
    end

`ifdef AQUILA_DEV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
`endif

    state_e state_q, state_d;

    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [ADDR_WIDTH-1:0] mem_addr  [DEPTH];
    logic                  mem_rw    [DEPTH];
    logic [BE_WIDTH-1:0]   mem_be    [DEPTH];
    logic [DATA_WIDTH-1:0] mem_wdata [DEPTH];

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifdef AQUILA_DEV_TIMEOUT_EN
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  error_q, error_d;
`endif

    logic empty, full, push, pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
                   (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
    assign push  = req_valid_i && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr[wptr_q[IDX_W-1:0]]  <= req_addr_i;
            mem_rw[wptr_q[IDX_W-1:0]]    <= req_rw_i;
            mem_be[wptr_q[IDX_W-1:0]]    <= req_be_i;
            mem_wdata[wptr_q[IDX_W-1:0]] <= req_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            state_q <= S_IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef AQUILA_DEV_TIMEOUT_EN
            cnt_q   <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef AQUILA_DEV_TIMEOUT_EN
            cnt_q   <= cnt_d;
            error_q <= error_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef AQUILA_DEV_TIMEOUT_EN
        cnt_d   = cnt_q;
        error_d = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    addr_d  = mem_addr[rptr_q[IDX_W-1:0]];
                    rw_d    = mem_rw[rptr_q[IDX_W-1:0]];
                    be_d    = mem_be[rptr_q[IDX_W-1:0]];
                    wdata_d = mem_wdata[rptr_q[IDX_W-1:0]];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef AQUILA_DEV_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A data_ready coinciding with expiry still completes normally.
                if (dev_data_ready_i) begin
                    rdata_d = rw_q ? '0 : dev_dev2core_data_i;
`ifdef AQUILA_DEV_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef AQUILA_DEV_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = rw_q ? '0 : DATA_WIDTH'(32'hDEAD_BEEF);
                    error_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
`ifdef AQUILA_DEV_TIMEOUT_EN
                state_d = error_q ? S_DRAIN : S_IDLE;
`else
                state_d = S_IDLE;
`endif
            end
`ifdef AQUILA_DEV_TIMEOUT_EN
            // The late completion of a timed-out request is swallowed here.
            S_DRAIN: begin
                if (dev_data_ready_i) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o         = !full;
    assign rsp_valid_o         = (state_q == S_RESP);
    assign rsp_rw_o            = rw_q;
    assign rsp_rdata_o         = rdata_q;
`ifdef AQUILA_DEV_TIMEOUT_EN
    assign rsp_error_o         = error_q;
`else
    assign rsp_error_o         = 1'b0;
`endif
    assign dev_strobe_o        = (state_q == S_ISSUE);
    assign dev_addr_o          = addr_q;
    assign dev_rw_o            = rw_q;
    assign dev_byte_enable_o   = be_q;
    assign dev_core2dev_data_o = wdata_q;
    assign busy_o              = (state_q != S_IDLE) || !empty;

endmodule
